// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 receiver and arrow/shift/space key-state decoder
//
// Receives raw PS/2 frames, validates start/parity/stop and a per-frame
// timeout, then decodes make/break scancodes into held/released key levels.
//
// Ports:
//   clk, resetN         system clock, asynchronous active-low reset
//   ps2Clk, ps2Data     raw keyboard pins (asynchronous to clk)
//   rightArrow          right arrow held (E0-prefixed RIGHT_CODE)
//   leftArrow           left arrow held (E0-prefixed LEFT_CODE)
//   superSpeed          speed key held (SPEED_CODE, no prefix)
//   fire                fire key held (FIRE_CODE, no prefix)
//   byteValid           one-cycle strobe, good frame received
//   byteOut             last good byte, held between strobes
//   frameErr            one-cycle strobe, parity/stop/timeout error
module ps2_key_decoder #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74,
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter logic [7:0]  SPEED_CODE     = 8'h12,
    parameter logic [7:0]  FIRE_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       rightArrow,
    output logic       leftArrow,
    output logic       superSpeed,
    output logic       fire,
    output logic       byteValid,
    output logic [7:0] byteOut,
    output logic       frameErr
);

    localparam int                GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, RX} state_t;

    logic [1:0]       clkSync;
    logic [1:0]       dataSync;
    logic             clkPrev;
    logic             fall;
    logic             bitIn;
    logic [GAP_W-1:0] gapCnt;
    logic             timeoutHit;

    state_t           state, stateNext;
    logic [3:0]       bitCnt, bitCntNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             parityBit, parityNext;

    logic             frameDone;
    logic             frameGood;
    logic             validNext;
    logic             errNext;

    logic             ext;
    logic             brk;

    // Synchronizers reset to 0 so a high idle line after reset never looks
    // like a falling edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clkSync  <= 2'b00;
            dataSync <= 2'b00;
            clkPrev  <= 1'b0;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fall  = clkPrev & ~clkSync[1];
    assign bitIn = dataSync[1];

    // Gap counter: cleared by every edge, saturates at the timeout value.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gapCnt <= '0;
        end else if (fall) begin
            gapCnt <= '0;
        end else if (gapCnt != GAP_MAX) begin
            gapCnt <= gapCnt + GAP_W'(1);
        end
    end

    assign timeoutHit = (state == RX) && !fall && (gapCnt == GAP_MAX);

    // Receiver state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            bitCnt    <= 4'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
        end
    end

    // Receiver next-state logic. A new start bit clears the shifter, so a
    // frame abandoned by timeout never leaks into the next byte.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        case (state)
            IDLE: begin
                if (fall && !bitIn) begin
                    stateNext  = RX;
                    bitCntNext = 4'd1;
                    shiftNext  = 8'h00;
                end
            end
            RX: begin
                if (timeoutHit) begin
                    stateNext  = IDLE;
                    bitCntNext = 4'd0;
                end else if (fall) begin
                    if (bitCnt <= 4'd8) begin
                        shiftNext  = {bitIn, shiftReg[7:1]};
                        bitCntNext = bitCnt + 4'd1;
                    end else if (bitCnt == 4'd9) begin
                        parityNext = bitIn;
                        bitCntNext = 4'd10;
                    end else begin
                        stateNext  = IDLE;
                        bitCntNext = 4'd0;
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                bitCntNext = 4'd0;
            end
        endcase
    end

    // Receiver output decode; the strobes themselves are registered below.
    always_comb begin
        frameDone = (state == RX) && fall && (bitCnt == 4'd10);
        frameGood = frameDone && bitIn && (^{shiftReg, parityBit});
        validNext = frameGood;
        errNext   = (frameDone && !frameGood) || timeoutHit;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            byteOut   <= 8'h00;
        end else begin
            byteValid <= validNext;
            frameErr  <= errNext;
            if (validNext) begin
                byteOut <= shiftReg;
            end
        end
    end

    // Scancode decoder: E0/F0 arm the prefix flags, the next code consumes
    // them. A receive error drops any pending prefix.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            rightArrow <= 1'b0;
            leftArrow  <= 1'b0;
            superSpeed <= 1'b0;
            fire       <= 1'b0;
        end else if (frameErr) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byteValid) begin
            case (byteOut)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                8'h00, 8'hFF: begin
                    ext        <= 1'b0;
                    brk        <= 1'b0;
                    rightArrow <= 1'b0;
                    leftArrow  <= 1'b0;
                    superSpeed <= 1'b0;
                    fire       <= 1'b0;
                end
                default: begin
                    if (ext && byteOut == RIGHT_CODE)  rightArrow <= !brk;
                    if (ext && byteOut == LEFT_CODE)   leftArrow  <= !brk;
                    if (!ext && byteOut == SPEED_CODE) superSpeed <= !brk;
                    if (!ext && byteOut == FIRE_CODE)  fire       <= !brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic       rightArrow, leftArrow, superSpeed, fire;
    logic       byteValid, frameErr;
    logic [7:0] byteOut;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .rightArrow (rightArrow),
        .leftArrow  (leftArrow),
        .superSpeed (superSpeed),
        .fire       (fire),
        .byteValid  (byteValid),
        .byteOut    (byteOut),
        .frameErr   (frameErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmpCount = 0;
    int errCount = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor
    int   bvCount = 0, feCount = 0, bvCycle = 0, raCycle = 0;
    logic prevBv = 1'b0, prevFe = 1'b0, prevRa = 1'b0;
    always @(negedge clk) begin
        if (byteValid === 1'b1) begin
            bvCount++;
            bvCycle = cyc;
            chk("strobe_overlap", 32'(frameErr), 32'd0);
            chk("byteValid_width", 32'(prevBv), 32'd0);
        end
        if (frameErr === 1'b1) begin
            feCount++;
            chk("frameErr_width", 32'(prevFe), 32'd0);
        end
        if (rightArrow !== prevRa) raCycle = cyc;
        prevBv = byteValid;
        prevFe = frameErr;
        prevRa = rightArrow;
    end

    // Reference model: key table indexed {right, left, speed, fire}
    logic [7:0] keyCode [4] = '{8'h74, 8'h6B, 8'h12, 8'h29};
    logic       keyExt  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] mKeys = 4'b0;
    logic       mExt = 1'b0, mBrk = 1'b0;
    logic [7:0] mByte = 8'h00;
    int         mBv = 0, mFe = 0;

    task automatic modelGood(input logic [7:0] b);
        mBv++;
        mByte = b;
        if (b == 8'hE0) mExt = 1'b1;
        else if (b == 8'hF0) mBrk = 1'b1;
        else if (b == 8'h00 || b == 8'hFF) begin
            mKeys = 4'b0; mExt = 1'b0; mBrk = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (keyCode[k] == b && keyExt[k] == mExt) mKeys[k] = !mBrk;
            mExt = 1'b0; mBrk = 1'b0;
        end
    endtask

    task automatic modelErr();
        mFe++;
        mExt = 1'b0;
        mBrk = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "_right"}, 32'(rightArrow), 32'(mKeys[0]));
        chk({tag, "_left"},  32'(leftArrow),  32'(mKeys[1]));
        chk({tag, "_speed"}, 32'(superSpeed), 32'(mKeys[2]));
        chk({tag, "_fire"},  32'(fire),       32'(mKeys[3]));
        chk({tag, "_byteOut"}, 32'(byteOut), 32'(mByte));
        chk({tag, "_nValid"}, 32'(bvCount), 32'(mBv));
        chk({tag, "_nErr"},   32'(feCount), 32'(mFe));
    endtask

    // Pin driver: data changes while ps2Clk is high, one falling edge per bit
    int fallCyc = 0;
    task automatic pinBit(input logic d);
        @(negedge clk);
        ps2Data = d;
        repeat (HALF / 2) @(negedge clk);
        ps2Clk = 1'b0;
        fallCyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic badStop);
        pinBit(1'b0);
        for (int i = 0; i < 8; i++) pinBit(b[i]);
        pinBit((~^b) ^ badPar);
        pinBit(!badStop);
        @(negedge clk);
        ps2Data = 1'b1;
        repeat (8) @(negedge clk);
        if (badPar || badStop) modelErr();
        else modelGood(b);
    endtask

    task automatic sendGood(input logic [7:0] b);
        sendFrame(b, 1'b0, 1'b0);
    endtask

    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h12, 8'h29, 8'hFF, 8'hAA, 8'hFA, 8'h00};

    initial begin
        logic [7:0] b;
        logic       bp, bs;

        // Reset state
        repeat (5) @(negedge clk);
        checkAll("reset");
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        // 1: right arrow press with latency check, then release
        sendGood(8'hE0);
        sendGood(8'h74);
        chk("bv_latency", 32'(bvCycle - fallCyc), 32'd3);
        chk("ra_latency", 32'(raCycle - fallCyc), 32'd4);
        checkAll("right_press");
        sendGood(8'hE0);
        sendGood(8'hF0);
        sendGood(8'h74);
        checkAll("right_release");

        // 2: shift plus left arrow, release shift only
        sendGood(8'h12);
        sendGood(8'hE0);
        sendGood(8'h6B);
        checkAll("shift_left");
        sendGood(8'hF0);
        sendGood(8'h12);
        checkAll("shift_release");

        // 3: bad parity drops the E0 prefix
        sendGood(8'hE0);
        sendFrame(8'h74, 1'b1, 1'b0);
        checkAll("bad_parity");
        sendGood(8'h74);
        checkAll("unprefixed_74");

        // 4: timeout after start + 4 data bits
        pinBit(1'b0);
        for (int i = 0; i < 4; i++) pinBit(1'($urandom_range(0, 1)));
        repeat (TO + 20) @(negedge clk);
        modelErr();
        checkAll("timeout");
        repeat (TO) @(negedge clk);
        checkAll("idle_no_timeout");
        sendGood(8'h29);
        checkAll("fire_after_timeout");

        // 5: overrun with all four held
        sendGood(8'h12);
        sendGood(8'hE0);
        sendGood(8'h74);
        sendGood(8'hE0);
        sendGood(8'h6B);
        checkAll("all_held");
        sendGood(8'hFF);
        checkAll("overrun");

        // Randomized traffic including bad parity and bad stop bits
        for (int n = 0; n < 40; n++) begin
            b  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 9) == 0);
            sendFrame(b, bp, bs);
            checkAll("random");
        end

        // 6: reset during bit 5 of an E0-prefixed 74
        sendGood(8'h29);
        sendGood(8'hE0);
        sendGood(8'h74);
        sendGood(8'hE0);
        pinBit(1'b0);
        for (int i = 0; i < 4; i++) pinBit(((8'h74 >> i) & 8'h01) != 0);
        @(negedge clk);
        ps2Data = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        repeat (5) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (5) @(negedge clk);
        mKeys = 4'b0; mExt = 1'b0; mBrk = 1'b0; mByte = 8'h00;
        checkAll("reset_mid_frame");
        resetN = 1'b1;
        repeat (TO + 20) @(negedge clk);
        checkAll("after_reset_idle");
        sendGood(8'hE0);
        sendGood(8'h74);
        checkAll("right_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Keyboard front end that produces the `rightArrow`, `leftArrow` and `superSpeed` levels consumed by the player movement logic, plus a `fire` level for the shot logic. It receives raw PS/2 frames from the keyboard pins, validates them and decodes set-2 make/break scancodes into per-key held/released state. It runs in the system `clk` domain, and its outputs connect directly to the player and shot blocks.

## Interface
- `TIMEOUT_CYCLES`, default 100000: clk cycles without a ps2Clk falling edge before a partial frame is aborted (2 ms at 50 MHz).
- `RIGHT_CODE`, default 8'h74: right arrow, extended (E0-prefixed).
- `LEFT_CODE`, default 8'h6B: left arrow, extended.
- `SPEED_CODE`, default 8'h12: left shift, non-extended; drives superSpeed.
- `FIRE_CODE`, default 8'h29: space, non-extended.

- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `ps2Clk` in 1: raw keyboard clock, asynchronous.
- `ps2Data` in 1: raw keyboard data, asynchronous.
- `rightArrow` out 1: right arrow held.
- `leftArrow` out 1: left arrow held.
- `superSpeed` out 1: speed key held.
- `fire` out 1: fire key held.
- `byteValid` out 1: one-cycle strobe; a good frame was received.
- `byteOut` out 8: last good byte; held between strobes.
- `frameErr` out 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- **Input sync:** 2-FF synchronizer on each of ps2Clk and ps2Data. `fall` = registered sync clk was 1 and sync clk is now 0. Data is sampled at `fall`.
- **Receiver FSM**, states IDLE and RX, with a 4-bit bit counter:
  - IDLE: `fall` with data=0 is the start bit; go to RX with cnt=1. `fall` with data=1 is ignored.
  - RX: on each `fall`, cnt 1–8 shifts data in LSB-first, cnt 9 captures parity, cnt 10 checks the stop bit.
  - At cnt 10, if stop=1 and the 8 data bits plus parity hold an odd number of ones: pulse byteValid and load byteOut. Otherwise pulse frameErr. Either way, return to IDLE.
- **Timeout:** the gap counter clears on every `fall` and saturates. In RX, when it reaches TIMEOUT_CYCLES: pulse frameErr, go to IDLE, drop the partial byte. The timeout is inactive in IDLE.
- **Decoder flags** `ext` and `brk`, acting on each byteValid:
  - E0: set ext.
  - F0: set brk.
  - 00 or FF (overrun): clear all four key outputs, ext and brk.
  - Any other code: if {ext, code} matches a key, set that key to !brk. Then clear ext and brk. Unmatched codes (including FA, AA, E1) only clear the flags.
  - RIGHT_CODE and LEFT_CODE match only with ext=1. SPEED_CODE and FIRE_CODE match only with ext=0.
- frameErr also clears ext and brk, so the following byte is decoded as unprefixed.
- Keys are independent. Both arrows may be 1 at once; the movement logic resolves the conflict.
- Typematic repeat (repeated make codes) re-asserts 1 with no side effect.

## Timing
- **Reset:** all outputs 0, byteOut=8'h00, FSM in IDLE, counters 0, ext=brk=0.
  - Reset asserted mid-frame discards the frame.
  - The first clean start bit after release is received normally.
- **Latency:**
  - The stop-bit falling edge at the pin produces byteValid 3 clk later (2 sync + edge register), ±1 clk for sampling phase.
  - Key outputs change on the clk after byteValid.
- byteValid and frameErr are never high in the same cycle, and each is exactly 1 cycle wide.
- All outputs are registered and glitch-free. Key levels hold between events.
- PS/2 clock is 10–16.7 kHz. Consecutive `fall` events are always at least 1000 clk apart, so there is no back-pressure and no buffering.
- The gap counter is wide enough for TIMEOUT_CYCLES (17 bits at the default value).

## Test plan
1. **Right arrow press/release:** send frames E0,74 -> rightArrow=1 within 4 clk of the second stop edge, byteOut=8'h74. Then send E0,F0,74 -> rightArrow=0; the other outputs stay 0.
2. **Shift plus left arrow:** send 12 then E0,6B -> superSpeed=1 and leftArrow=1. Send F0,12 -> superSpeed=0 while leftArrow stays 1.
3. **Bad parity:** send E0, then 74 with the parity bit flipped -> one frameErr pulse, no byteValid, rightArrow=0. Then send a good 74 -> no key change, because the unprefixed 74 does not match.
4. **Timeout:** send a start bit plus 4 data bits, then hold ps2Clk high for TIMEOUT_CYCLES -> frameErr pulse, FSM returns to IDLE. Then send a full 29 frame -> fire=1.
5. **Overrun:** with all four keys held, send FF -> all four outputs 0 on the clk after byteValid.
6. **Reset mid-frame:** pulse resetN low during bit 5 of an E0-prefixed 74 -> all outputs 0. Then send E0,74 -> rightArrow=1.
